// File: rtl/bike_move_sched.sv
// Per-tick lightbike sequencer: bounds check, trail read, head-on check and trail
// write for both bikes through one shared framebuffer port.
module bike_move_sched #(
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 450,
  parameter int          P1_START = 144100,
  parameter int          P2_START = 144500,
  parameter logic [2:0]  P1_COLOR = 3'd1,
  parameter logic [2:0]  P2_COLOR = 3'd2,
  parameter int          RD_LAT   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic [1:0]         p1_dir,
  input  logic [1:0]         p2_dir,
  output logic [18:0]        fb_addr,
  output logic               fb_rden,
  input  logic [2:0]         fb_rdata,
  output logic               fb_wren,
  output logic [2:0]         fb_wdata,
  output logic [18:0]        p1_addr,
  output logic [18:0]        p2_addr,
  output logic signed [31:0] p1_orient,
  output logic signed [31:0] p2_orient,
  output logic               busy,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_BOUND1  = 4'd1;
  localparam logic [3:0] S_RD1     = 4'd2;
  localparam logic [3:0] S_WAIT1   = 4'd3;
  localparam logic [3:0] S_BOUND2  = 4'd4;
  localparam logic [3:0] S_RD2     = 4'd5;
  localparam logic [3:0] S_WAIT2   = 4'd6;
  localparam logic [3:0] S_WRITE1  = 4'd7;
  localparam logic [3:0] S_WRITE2  = 4'd8;
  localparam logic [3:0] S_RESOLVE = 4'd9;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  logic [3:0]  state;
  logic [1:0]  dir1, dir2;
  logic [18:0] next1, next2;
  logic        crash1, crash2;
  logic [3:0]  wcnt;

  logic        bnd1, bnd2;
  logic [18:0] nxt1, nxt2;

  function automatic logic signed [31:0] step_of(input logic [1:0] d);
    logic signed [31:0] s;
    case (d)
      DIR_UP:   s = -SCREEN_W;
      DIR_DOWN: s = SCREEN_W;
      DIR_LEFT: s = -1;
      default:  s = 1;
    endcase
    return s;
  endfunction

  function automatic logic at_edge(input logic [18:0] a, input logic [1:0] d);
    logic [31:0] a32;
    logic        e;
    a32 = 32'(a);
    case (d)
      DIR_UP:   e = (a32 < SCREEN_W);
      DIR_DOWN: e = (a32 >= SCREEN_W * (SCREEN_H - 1));
      DIR_LEFT: e = ((a32 % SCREEN_W) == 0);
      default:  e = ((a32 % SCREEN_W) == SCREEN_W - 1);
    endcase
    return e;
  endfunction

  // Only consumed when at_edge() is false, so the truncation never wraps.
  function automatic logic [18:0] next_of(input logic [18:0] a, input logic [1:0] d);
    logic signed [31:0] sum;
    sum = $signed(32'(a)) + step_of(d);
    return sum[18:0];
  endfunction

  // A request for the exact reverse of the current heading is dropped.
  function automatic logic [1:0] latch_dir(input logic [1:0] req, input logic [1:0] cur);
    return (req == (cur ^ 2'd1)) ? cur : req;
  endfunction

  always_comb begin
    bnd1 = at_edge(p1_addr, dir1);
    bnd2 = at_edge(p2_addr, dir2);
    nxt1 = next_of(p1_addr, dir1);
    nxt2 = next_of(p2_addr, dir2);
  end

  assign p1_orient = step_of(dir1);
  assign p2_orient = step_of(dir2);
  assign busy      = (state != S_IDLE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      p1_addr   <= 19'(P1_START);
      p2_addr   <= 19'(P2_START);
      dir1      <= DIR_RIGHT;
      dir2      <= DIR_LEFT;
      next1     <= '0;
      next2     <= '0;
      crash1    <= 1'b0;
      crash2    <= 1'b0;
      wcnt      <= '0;
      game_over <= 1'b1;
      winner    <= 2'd0;
      fb_addr   <= '0;
      fb_rden   <= 1'b0;
      fb_wren   <= 1'b0;
      fb_wdata  <= '0;
    end else if (start) begin
      state     <= S_IDLE;
      p1_addr   <= 19'(P1_START);
      p2_addr   <= 19'(P2_START);
      dir1      <= DIR_RIGHT;
      dir2      <= DIR_LEFT;
      crash1    <= 1'b0;
      crash2    <= 1'b0;
      wcnt      <= '0;
      game_over <= 1'b0;
      winner    <= 2'd0;
      fb_rden   <= 1'b0;
      fb_wren   <= 1'b0;
    end else begin
      // NOTE: strobes default low each clock so every access is a single-cycle pulse.
      fb_rden <= 1'b0;
      fb_wren <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick && !game_over) begin
            dir1   <= latch_dir(p1_dir, dir1);
            dir2   <= latch_dir(p2_dir, dir2);
            crash1 <= 1'b0;
            crash2 <= 1'b0;
            state  <= S_BOUND1;
          end
        end
        S_BOUND1: begin
          next1  <= nxt1;
          crash1 <= bnd1;
          state  <= bnd1 ? S_BOUND2 : S_RD1;
        end
        S_RD1: begin
          fb_addr <= next1;
          fb_rden <= 1'b1;
          wcnt    <= '0;
          state   <= S_WAIT1;
        end
        S_WAIT1: begin
          if (wcnt == 4'(RD_LAT)) begin
            if (fb_rdata != 3'd0) crash1 <= 1'b1;
            state <= S_BOUND2;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_BOUND2: begin
          next2 <= nxt2;
          if (bnd2) begin
            crash2 <= 1'b1;
            state  <= S_WRITE1;
          end else if (!crash1 && (nxt2 == next1)) begin
            // Head-on into the same empty cell: neither bike survives.
            crash1 <= 1'b1;
            crash2 <= 1'b1;
            state  <= S_WRITE1;
          end else begin
            state <= S_RD2;
          end
        end
        S_RD2: begin
          fb_addr <= next2;
          fb_rden <= 1'b1;
          wcnt    <= '0;
          state   <= S_WAIT2;
        end
        S_WAIT2: begin
          if (wcnt == 4'(RD_LAT)) begin
            if (fb_rdata != 3'd0) crash2 <= 1'b1;
            state <= S_WRITE1;
          end else begin
            wcnt <= wcnt + 4'd1;
          end
        end
        S_WRITE1: begin
          if (!crash1) begin
            fb_addr  <= next1;
            fb_wren  <= 1'b1;
            fb_wdata <= P1_COLOR;
            p1_addr  <= next1;
          end
          state <= S_WRITE2;
        end
        S_WRITE2: begin
          if (!crash2) begin
            fb_addr  <= next2;
            fb_wren  <= 1'b1;
            fb_wdata <= P2_COLOR;
            p2_addr  <= next2;
          end
          state <= S_RESOLVE;
        end
        S_RESOLVE: begin
          case ({crash1, crash2})
            2'b01: begin winner <= 2'd1; game_over <= 1'b1; end
            2'b10: begin winner <= 2'd2; game_over <= 1'b1; end
            2'b11: begin winner <= 2'd3; game_over <= 1'b1; end
            default: ;
          endcase
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bike_move_sched.sv
// Directed bench for bike_move_sched: framebuffer model with RD_LAT read pipe,
// write scoreboard and a behavioural bike model driving the expectations.
module tb_bike_move_sched;

  localparam int W = 640;
  localparam int H = 450;
  localparam int NPIX = W * H;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               tick  = 1'b0;
  logic [1:0]         p1_dir = 2'd3;
  logic [1:0]         p2_dir = 2'd2;
  logic [18:0]        fb_addr;
  logic               fb_rden;
  logic [2:0]         fb_rdata;
  logic               fb_wren;
  logic [2:0]         fb_wdata;
  logic [18:0]        p1_addr, p2_addr;
  logic signed [31:0] p1_orient, p2_orient;
  logic               busy, game_over;
  logic [1:0]         winner;

  bike_move_sched dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick),
    .p1_dir(p1_dir), .p2_dir(p2_dir),
    .fb_addr(fb_addr), .fb_rden(fb_rden), .fb_rdata(fb_rdata),
    .fb_wren(fb_wren), .fb_wdata(fb_wdata),
    .p1_addr(p1_addr), .p2_addr(p2_addr),
    .p1_orient(p1_orient), .p2_orient(p2_orient),
    .busy(busy), .game_over(game_over), .winner(winner)
  );

  always #5 clock = ~clock;

  logic [2:0]  fbm [0:NPIX-1];
  logic [18:0] rp_a0 = '0, rp_a1 = '0;

  // Two-stage read pipe: data for an address strobed in cycle c appears in cycle c+2.
  always @(posedge clock) begin
    rp_a0 <= fb_addr;
    rp_a1 <= rp_a0;
  end
  always_comb fb_rdata = (32'(rp_a1) < NPIX) ? fbm[rp_a1] : 3'd0;

  int total = 0;
  int bad   = 0;
  int rd_count = 0;
  int wr_count = 0;
  logic [21:0] sb [$];

  // bike model
  int         m_p1, m_p2, m_win;
  logic [1:0] m_d1, m_d2;
  bit         m_over = 1'b1;
  bit         m_crash, m_headon;
  int         m_reads;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int stepv(input logic [1:0] d);
    case (d)
      2'd0: return -W;
      2'd1: return W;
      2'd2: return -1;
      default: return 1;
    endcase
  endfunction

  function automatic bit off_screen(input int a, input logic [1:0] d);
    int row, col;
    row = a / W;
    col = a % W;
    case (d)
      2'd0: return row == 0;
      2'd1: return row == H - 1;
      2'd2: return col == 0;
      default: return col == W - 1;
    endcase
  endfunction

  task automatic monitor();
    logic [21:0] e;
    forever begin
      @(negedge clock);
      if (fb_rden || fb_wren) check("port_excl", 32'(fb_rden & fb_wren), 0);
      if (fb_rden) rd_count++;
      if (fb_wren) begin
        wr_count++;
        check("write_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("write_addr", 32'(fb_addr), 32'(e[21:3]));
          check("write_data", 32'(fb_wdata), 32'(e[2:0]));
        end
        if (32'(fb_addr) < NPIX) fbm[fb_addr] = fb_wdata;
      end
    end
  endtask

  task automatic clear_fb();
    for (int i = 0; i < NPIX; i++) fbm[i] = 3'd0;
  endtask

  task automatic model_reload();
    m_p1 = 144100; m_p2 = 144500;
    m_d1 = 2'd3;   m_d2 = 2'd2;
    m_over = 1'b0; m_win = 0;
  endtask

  task automatic do_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    clear_fb();
    model_reload();
    @(negedge clock);
  endtask

  // Predicts one accepted tick and queues the expected trail writes.
  task automatic model_tick(input logic [1:0] d1, input logic [1:0] d2);
    bit b1, b2, c1, c2;
    int n1, n2;
    m_crash = 1'b0; m_headon = 1'b0; m_reads = 0;
    if (m_over) return;
    if (d1 != (m_d1 ^ 2'd1)) m_d1 = d1;
    if (d2 != (m_d2 ^ 2'd1)) m_d2 = d2;
    b1 = off_screen(m_p1, m_d1);
    b2 = off_screen(m_p2, m_d2);
    n1 = m_p1 + stepv(m_d1);
    n2 = m_p2 + stepv(m_d2);
    c1 = b1; c2 = b2;
    m_reads = (b1 ? 0 : 1) + (b2 ? 0 : 1);
    if (!b1 && !b2 && n1 == n2) begin
      c1 = 1'b1; c2 = 1'b1; m_headon = 1'b1;
    end else begin
      if (!b1 && fbm[n1] != 3'd0) c1 = 1'b1;
      if (!b2 && fbm[n2] != 3'd0) c2 = 1'b1;
    end
    if (!c1) begin sb.push_back({19'(n1), 3'd1}); m_p1 = n1; end
    if (!c2) begin sb.push_back({19'(n2), 3'd2}); m_p2 = n2; end
    m_crash = c1 | c2;
    if (m_crash) begin
      m_over = 1'b1;
      m_win  = (c1 && c2) ? 3 : (c1 ? 2 : 1);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_p1_addr"}, 32'(p1_addr), 32'(m_p1));
    check({tag, "_p2_addr"}, 32'(p2_addr), 32'(m_p2));
    check({tag, "_p1_orient"}, p1_orient, stepv(m_d1));
    check({tag, "_p2_orient"}, p2_orient, stepv(m_d2));
    check({tag, "_game_over"}, 32'(game_over), 32'(m_over));
    check({tag, "_winner"}, 32'(winner), 32'(m_win));
  endtask

  task automatic do_tick(input logic [1:0] d1, input logic [1:0] d2);
    int  n, rd_base;
    bit  accepted;
    accepted = !m_over;
    model_tick(d1, d2);
    rd_base = rd_count;
    @(negedge clock); p1_dir = d1; p2_dir = d2; tick = 1'b1;
    @(negedge clock); tick = 1'b0; n = 1;
    while (busy && n < 200) begin @(negedge clock); n++; end
    check("idle_in_time", 32'(busy), 0);
    check("sb_drained", 32'(sb.size()), 0);
    if (accepted && !m_crash) check("latency", 32'(n - 1), 13);
    if (accepted && !m_headon) check("read_count", 32'(rd_count - rd_base), 32'(m_reads));
    if (!accepted) check("ignored_tick_reads", 32'(rd_count - rd_base), 0);
    check_state("tick");
  endtask

  task automatic walk(input int n, input logic [1:0] d1, input logic [1:0] d2);
    repeat (n) do_tick(d1, d2);
  endtask

  initial begin
    int wr_base, n;
    fork monitor(); join_none
    clear_fb();
    m_p1 = 144100; m_p2 = 144500; m_d1 = 2'd3; m_d2 = 2'd2; m_win = 0; m_over = 1'b1;

    // reset values
    #12 reset = 1'b0;
    @(negedge clock);
    check_state("reset");
    check("reset_busy", 32'(busy), 0);
    check("reset_rden", 32'(fb_rden), 0);
    check("reset_wren", 32'(fb_wren), 0);
    check("reset_fb_addr", 32'(fb_addr), 0);
    check("reset_fb_wdata", 32'(fb_wdata), 0);

    // game_over after reset: tick ignored
    do_tick(2'd0, 2'd0);

    // basic move: right / left into an empty framebuffer
    do_start();
    check_state("start");
    do_tick(2'd3, 2'd2);

    // reversal dropped, then a legal turn up
    do_tick(2'd2, 2'd2);
    do_tick(2'd0, 2'd2);

    // trail crash: fake P2 trail at P1's next cell
    do_start();
    fbm[144101] = 3'd2;
    do_tick(2'd3, 2'd2);
    do_tick(2'd3, 2'd2);

    // start during WAIT1 aborts the sequence
    do_start();
    wr_base = wr_count;
    @(negedge clock); p1_dir = 2'd3; p2_dir = 2'd2; tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    @(negedge clock);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    model_reload();
    repeat (20) @(negedge clock);
    check("abort_writes", 32'(wr_count - wr_base), 0);
    check("abort_busy", 32'(busy), 0);
    check_state("abort");

    // a second tick while busy is dropped
    wr_base = wr_count;
    model_tick(2'd3, 2'd2);
    @(negedge clock); p1_dir = 2'd3; p2_dir = 2'd2; tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    repeat (4) @(negedge clock);
    p1_dir = 2'd0; p2_dir = 2'd0; tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge clock); n++; end
    repeat (20) @(negedge clock);
    check("busy_tick_writes", 32'(wr_count - wr_base), 2);
    check("busy_tick_sb", 32'(sb.size()), 0);
    check_state("busy_tick");

    // P1 drives to 639 and off the right edge; P2 survives along the bottom
    do_start();
    walk(224, 2'd0, 2'd1);
    walk(1,   2'd0, 2'd2);
    walk(499, 2'd3, 2'd2);
    walk(40,  2'd3, 2'd0);
    check("edge_p1_at_639", 32'(p1_addr), 639);
    do_tick(2'd3, 2'd0);
    check("edge_winner", 32'(winner), 2);

    // head-on: P1 at 1000 moving right, P2 at 1002 moving left
    do_start();
    walk(61,  2'd0, 2'd1);
    walk(1,   2'd0, 2'd2);
    walk(162, 2'd0, 2'd0);
    walk(123, 2'd3, 2'd0);
    walk(137, 2'd3, 2'd2);
    check("headon_p1_at_1000", 32'(p1_addr), 1000);
    check("headon_p2_at_1002", 32'(p2_addr), 1002);
    wr_base = wr_count;
    do_tick(2'd3, 2'd2);
    check("headon_writes", 32'(wr_count - wr_base), 0);
    check("headon_winner", 32'(winner), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
